// File: rtl/reg_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_stream_pkg
// Brief    : Shared types and default sizing for the register stream reader.
// Revision : 1.0 - initial release
// ============================================================================
package reg_stream_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_stream_reader_if
// Brief    : Write port, control strobes and valid/ready output stream.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_stream_reader_if
    import reg_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [WIDTH-1:0]  wr_data;
    logic                     clr;
    logic                     start;
    logic                     busy;
    logic signed [WIDTH-1:0]  m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_last;
    logic                     done;

    // Producer/consumer side: drives writes, commands and ready.
    modport master (
        output wr_en, wr_addr, wr_data, clr, start, m_ready,
        input  busy, m_data, m_valid, m_last, done
    );

    // Reader side.
    modport slave (
        input  wr_en, wr_addr, wr_data, clr, start, m_ready,
        output busy, m_data, m_valid, m_last, done
    );
endinterface
`default_nettype wire

// File: rtl/reg_stream_reader_bank.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank
// Brief    : Signed word storage with write port, bulk clear, write inhibit
//            and combinational read mux.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank
    import reg_stream_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic                    clr,
    input  logic                    wr_inhibit,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic signed [WIDTH-1:0] rd_data
);
    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic signed [WIDTH-1:0] mem_d [DEPTH];
    logic                    w_addr_ok;

    // Only a non-power-of-two depth can see addresses past the last entry.
    if (DEPTH == (1 << ADDR_W)) begin : g_addr_full
        assign w_addr_ok = 1'b1;
    end else begin : g_addr_check
        assign w_addr_ok = ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
    end

    // Next bank contents: clear wins over write; both blocked while inhibited.
    always_comb begin
        mem_d = mem_q;
        if (!wr_inhibit) begin
            if (clr) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_d[i] = '0;
                end
            end else if (wr_en && w_addr_ok) begin
                mem_d[wr_addr] = wr_data;
            end
        end
    end

    // Storage flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];
endmodule
`default_nettype wire

// File: rtl/reg_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : reg_stream_reader
// Brief    : Drains a small register bank on command as a valid/ready stream
//            with a last marker and a completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module reg_stream_reader
    import reg_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    reg_stream_reader_if.slave bus
);
    localparam int                ADDR_W     = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(DEPTH - 1);

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       rd_idx_q, rd_idx_d;
    logic                    busy_q, busy_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic                    done_q, done_d;
    logic signed [WIDTH-1:0] w_rd_data;
    logic                    w_bank_frozen;

    // The bank only accepts updates while idle, so the stream sees a snapshot.
    assign w_bank_frozen = (state_q == ST_STREAM);

    reg_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .wr_data    (bus.wr_data),
        .clr        (bus.clr),
        .wr_inhibit (w_bank_frozen),
        .rd_addr    (rd_idx_q),
        .rd_data    (w_rd_data)
    );

    // Next-state and output-flag logic; a transfer advances the read index.
    always_comb begin
        state_d   = state_q;
        rd_idx_d  = rd_idx_q;
        busy_d    = busy_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_STREAM;
                    rd_idx_d  = '0;
                    busy_d    = 1'b1;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                end
            end
            ST_STREAM: begin
                if (m_valid_q && bus.m_ready) begin
                    if (m_last_q) begin
                        state_d   = ST_IDLE;
                        rd_idx_d  = '0;
                        busy_d    = 1'b0;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        rd_idx_d  = rd_idx_q + 1'b1;
                        m_last_d  = (rd_idx_d == c_last_idx);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_idx_q  <= '0;
            busy_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_idx_q  <= rd_idx_d;
            busy_q    <= busy_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
        end
    end

    // Index and bank are both frozen during a stream, so m_data holds under stall.
    assign bus.m_data  = m_valid_q ? w_rd_data : '0;
    assign bus.m_valid = m_valid_q;
    assign bus.m_last  = m_last_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
`default_nettype wire

// File: tb/tb_reg_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_stream_reader
// Brief    : Directed self-checking bench for reg_stream_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_stream_reader;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_stream_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    reg_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic signed [WIDTH-1:0] vals [DEPTH];
    logic signed [WIDTH-1:0] got_data [64];
    int   got_cnt, last_idx, drain_cycles, stall_err, early_done;
    logic timeout, post_busy, post_valid, post_last, post_done, post_done2, post_busy2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input logic signed [WIDTH-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(addr);
        bus.wr_data = data;
        tick;
        bus.wr_en   = 1'b0;
    endtask

    task automatic load_vals;
        for (int i = 0; i < DEPTH; i++) write_word(i, vals[i]);
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
    endtask

    // Consume one stream with a repeating ready pattern; records beats,
    // stall stability, stray done pulses and the flags around the final beat.
    task automatic drain(input logic [7:0] pat, input int plen, input logic restart);
        int pidx;
        logic fin, prev_stall, prev_last;
        logic signed [WIDTH-1:0] prev_data;
        pidx = 0; fin = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        got_cnt = 0; last_idx = -1; drain_cycles = 0; stall_err = 0; early_done = 0;
        timeout = 1'b0;
        while (!fin && !timeout) begin
            if (prev_stall && (bus.m_valid !== 1'b1 || bus.m_data !== prev_data ||
                               bus.m_last !== prev_last)) stall_err++;
            if (bus.done !== 1'b0) early_done++;
            bus.m_ready = pat[pidx % plen];
            pidx++;
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                if (got_cnt < 64) got_data[got_cnt] = bus.m_data;
                if (bus.m_last === 1'b1) begin
                    last_idx = got_cnt;
                    fin      = 1'b1;
                end
                got_cnt++;
            end
            prev_stall = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
            drain_cycles++;
            tick;
            if (drain_cycles > 200) timeout = 1'b1;
        end
        bus.m_ready = 1'b0;
        post_busy  = bus.busy;
        post_valid = bus.m_valid;
        post_last  = bus.m_last;
        post_done  = bus.done;
        bus.start  = restart;
        tick;
        bus.start  = 1'b0;
        post_done2 = bus.done;
        post_busy2 = bus.busy;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.m_valid); end
        vectors++; if (bus.m_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b expected 0", bus.m_last); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        vectors++; if (bus.m_data !== 16'sd0) begin miscompares++; $display("FAIL reset_data: got %0d expected 0", bus.m_data); end
        rst = 1'b0;
        tick;
        pulse_start;
        drain(8'hFF, 1, 1'b0);
        vectors++; if (got_cnt !== 8) begin miscompares++; $display("FAIL reset_beats: got %0d expected 8", got_cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (got_data[i] !== 16'sd0) begin miscompares++; $display("FAIL reset_beat%0d: got %0d expected 0", i, got_data[i]); end
        end
    endtask

    task automatic test_full_drain;
        load_vals;
        pulse_start;
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL start_busy: got %b expected 1", bus.busy); end
        vectors++; if (bus.m_valid !== 1'b1) begin miscompares++; $display("FAIL start_valid: got %b expected 1", bus.m_valid); end
        vectors++; if (bus.m_data !== vals[0]) begin miscompares++; $display("FAIL start_data: got %0d expected %0d", bus.m_data, vals[0]); end
        drain(8'hFF, 1, 1'b0);
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL full_timeout: got %b expected 0", timeout); end
        vectors++; if (got_cnt !== 8) begin miscompares++; $display("FAIL full_beats: got %0d expected 8", got_cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (got_data[i] !== vals[i]) begin miscompares++; $display("FAIL full_beat%0d: got %0d expected %0d", i, got_data[i], vals[i]); end
        end
        vectors++; if (last_idx !== 7) begin miscompares++; $display("FAIL full_last_idx: got %0d expected 7", last_idx); end
        vectors++; if (drain_cycles !== 8) begin miscompares++; $display("FAIL full_cycles: got %0d expected 8", drain_cycles); end
        vectors++; if (early_done !== 0) begin miscompares++; $display("FAIL full_early_done: got %0d expected 0", early_done); end
        vectors++; if ({post_busy, post_valid, post_last, post_done} !== 4'b0001) begin miscompares++; $display("FAIL full_post_flags: got %b expected 0001", {post_busy, post_valid, post_last, post_done}); end
        vectors++; if (post_done2 !== 1'b0) begin miscompares++; $display("FAIL full_done_width: got %b expected 0", post_done2); end
    endtask

    task automatic test_backpressure;
        // Ready pattern 1,0,0,1,0,1 repeating: transfers land on cycles
        // 0,3,5,6,9,11,12,15, so the stream spans 16 cycles.
        pulse_start;
        drain(8'h29, 6, 1'b0);
        vectors++; if (got_cnt !== 8) begin miscompares++; $display("FAIL bp_beats: got %0d expected 8", got_cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (got_data[i] !== vals[i]) begin miscompares++; $display("FAIL bp_beat%0d: got %0d expected %0d", i, got_data[i], vals[i]); end
        end
        vectors++; if (stall_err !== 0) begin miscompares++; $display("FAIL bp_stall_stable: got %0d expected 0", stall_err); end
        vectors++; if (drain_cycles !== 16) begin miscompares++; $display("FAIL bp_cycles: got %0d expected 16", drain_cycles); end
        vectors++; if (last_idx !== 7) begin miscompares++; $display("FAIL bp_last_idx: got %0d expected 7", last_idx); end
        vectors++; if ({post_busy, post_valid, post_last, post_done, post_done2} !== 5'b00010) begin miscompares++; $display("FAIL bp_post_flags: got %b expected 00010", {post_busy, post_valid, post_last, post_done, post_done2}); end
    endtask

    task automatic test_frozen;
        pulse_start;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 16'sd99;
        tick;
        bus.wr_en = 1'b0; bus.clr = 1'b1;
        tick;
        bus.clr = 1'b0;
        drain(8'hFF, 1, 1'b0);
        vectors++; if (got_cnt !== 8) begin miscompares++; $display("FAIL frozen_beats: got %0d expected 8", got_cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (got_data[i] !== vals[i]) begin miscompares++; $display("FAIL frozen_beat%0d: got %0d expected %0d", i, got_data[i], vals[i]); end
        end
        bus.clr = 1'b1;
        tick;
        bus.clr = 1'b0;
        pulse_start;
        drain(8'hFF, 1, 1'b0);
        vectors++; if (got_cnt !== 8) begin miscompares++; $display("FAIL clr_beats: got %0d expected 8", got_cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (got_data[i] !== 16'sd0) begin miscompares++; $display("FAIL clr_beat%0d: got %0d expected 0", i, got_data[i]); end
        end
    endtask

    task automatic test_same_cycle;
        // Bank is all zero here; write at start lands in entry 0.
        bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = -16'sd7;
        tick;
        bus.start = 1'b0; bus.wr_en = 1'b0;
        drain(8'hFF, 1, 1'b0);
        vectors++; if (got_data[0] !== -16'sd7) begin miscompares++; $display("FAIL start_wr_beat0: got %0d expected -7", got_data[0]); end
        vectors++; if (got_data[1] !== 16'sd0) begin miscompares++; $display("FAIL start_wr_beat1: got %0d expected 0", got_data[1]); end
        vectors++; if (got_cnt !== 8) begin miscompares++; $display("FAIL start_wr_beats: got %0d expected 8", got_cnt); end
        write_word(1, 16'sd5);
        write_word(7, 16'sd9);
        bus.start = 1'b1; bus.clr = 1'b1;
        tick;
        bus.start = 1'b0; bus.clr = 1'b0;
        drain(8'hFF, 1, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (got_data[i] !== 16'sd0) begin miscompares++; $display("FAIL start_clr_beat%0d: got %0d expected 0", i, got_data[i]); end
        end
    endtask

    task automatic test_mid_start;
        load_vals;
        pulse_start;
        bus.m_ready = 1'b1;
        tick;
        tick;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        drain(8'hFF, 1, 1'b0);
        vectors++; if (got_cnt !== 5) begin miscompares++; $display("FAIL mid_start_beats: got %0d expected 5", got_cnt); end
        vectors++; if (got_data[0] !== vals[3]) begin miscompares++; $display("FAIL mid_start_beat3: got %0d expected %0d", got_data[0], vals[3]); end
        vectors++; if (got_data[4] !== vals[7]) begin miscompares++; $display("FAIL mid_start_beat7: got %0d expected %0d", got_data[4], vals[7]); end
        vectors++; if ({bus.busy, bus.m_valid} !== 2'b00) begin miscompares++; $display("FAIL mid_start_no_restream: got %b expected 00", {bus.busy, bus.m_valid}); end
    endtask

    task automatic test_back_to_back;
        pulse_start;
        drain(8'hFF, 1, 1'b1);
        vectors++; if (post_done !== 1'b1) begin miscompares++; $display("FAIL b2b_done: got %b expected 1", post_done); end
        vectors++; if (post_busy2 !== 1'b1) begin miscompares++; $display("FAIL b2b_restart_busy: got %b expected 1", post_busy2); end
        drain(8'hFF, 1, 1'b0);
        vectors++; if (got_cnt !== 8) begin miscompares++; $display("FAIL b2b_beats: got %0d expected 8", got_cnt); end
        vectors++; if (got_data[7] !== vals[7]) begin miscompares++; $display("FAIL b2b_beat7: got %0d expected %0d", got_data[7], vals[7]); end
    endtask

    task automatic test_reset_mid;
        pulse_start;
        bus.m_ready = 1'b1;
        tick;
        tick;
        tick;
        rst = 1'b1;
        tick;
        vectors++; if ({bus.busy, bus.m_valid, bus.m_last, bus.done} !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_flags: got %b expected 0000", {bus.busy, bus.m_valid, bus.m_last, bus.done}); end
        rst = 1'b0;
        bus.m_ready = 1'b0;
        tick;
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_mid_done: got %b expected 0", bus.done); end
        pulse_start;
        drain(8'hFF, 1, 1'b0);
        vectors++; if (got_cnt !== 8) begin miscompares++; $display("FAIL rst_mid_beats: got %0d expected 8", got_cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (got_data[i] !== 16'sd0) begin miscompares++; $display("FAIL rst_mid_beat%0d: got %0d expected 0", i, got_data[i]); end
        end
    endtask

    initial begin
        vals = '{-16'sd3, -16'sd2, -16'sd1, 16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd32767};
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.clr = 1'b0; bus.start = 1'b0; bus.m_ready = 1'b0;
        test_reset;
        test_full_drain;
        test_backpressure;
        test_frozen;
        test_same_cycle;
        test_mid_start;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
